// File: rtl/qspi_lane_mode_ctrl.sv
// -----------------------------------------------------------------------------
// qspi_lane_mode_ctrl
//
// Flash bus-mode controller. Tracks the committed device mode (SPI x1, DPI x2,
// QPI x4, OPI x8) and decodes mode-switch opcodes accepted by the command
// sequencer. A legal switch is held pending until the current transaction ends
// (io_tran_done); it is then committed and a recovery window of RECOV_CYC
// cycles follows. Software can also force a mode through a valid/ready
// handshake. Per-phase lane select for the IO shifter is derived from the
// committed mode plus optional address/data phase overrides.
//
// Ports
//   clock, rst_n                    clock, asynchronous active-low reset
//   io_next_req, io_inst            accepted command pulse and its opcode
//   io_tran_done                    transaction finished (CS deasserted)
//   io_state_addr, io_state_data    shifter phase flags
//   io_addr_mode_en, io_addr_lanes  address phase lane override
//   io_data_mode_en, io_data_lanes  data phase lane override
//   io_force_valid, io_force_mode   software force-mode request
//   io_force_ready                  force request accepted this cycle
//   io_lane_sel                     lane code for the current phase
//   io_tran_mode                    committed device mode
//   io_mode_busy                    switch pending or recovering
//   io_mode_err                     one-cycle error pulse
//
// Lane codes: 00 SPI, 01 DPI, 10 QPI, 11 OPI.
// -----------------------------------------------------------------------------
module qspi_lane_mode_ctrl #(
    parameter int                INST_W    = 8,
    parameter bit                DPI_EN    = 1'b1,
    parameter bit                OPI_EN    = 1'b0,
    parameter logic [INST_W-1:0] QPIEN     = 8'h35,
    parameter logic [INST_W-1:0] QPIDI     = 8'hF5,
    parameter logic [INST_W-1:0] DPIEN     = 8'h37,
    parameter logic [INST_W-1:0] DPIDI     = 8'hFF,
    parameter logic [INST_W-1:0] OPIEN     = 8'hE8,
    parameter logic [INST_W-1:0] OPIDI     = 8'hE9,
    parameter int                RECOV_CYC = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              io_next_req,
    input  logic [INST_W-1:0] io_inst,
    input  logic              io_tran_done,
    input  logic              io_state_addr,
    input  logic              io_state_data,
    input  logic              io_addr_mode_en,
    input  logic [1:0]        io_addr_lanes,
    input  logic              io_data_mode_en,
    input  logic [1:0]        io_data_lanes,
    input  logic              io_force_valid,
    input  logic [1:0]        io_force_mode,
    output logic              io_force_ready,
    output logic [1:0]        io_lane_sel,
    output logic [1:0]        io_tran_mode,
    output logic              io_mode_busy,
    output logic              io_mode_err
);

    localparam logic [1:0] LANE_SPI = 2'b00;
    localparam logic [1:0] LANE_DPI = 2'b01;
    localparam logic [1:0] LANE_QPI = 2'b10;
    localparam logic [1:0] LANE_OPI = 2'b11;

    localparam bit         HAS_RECOV = (RECOV_CYC != 0);
    localparam logic [7:0] RECOV_LD  = 8'(RECOV_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        RECOV = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] mode_reg, mode_next;
    logic [1:0] pend_reg, pend_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       err_reg, err_next;

    logic       is_mode_op;
    logic       switch_legal;
    logic [1:0] switch_target;
    logic       force_accept;

    // Lane codes the attached device can actually run.
    function automatic logic lane_ok(input logic [1:0] code);
        if (code == LANE_DPI) return DPI_EN;
        if (code == LANE_OPI) return OPI_EN;
        return 1'b1;
    endfunction

    // Opcode classification against the committed mode. Opcodes of a
    // disabled mode are still mode opcodes, so they raise an error.
    always_comb begin
        is_mode_op    = (io_inst == QPIEN) || (io_inst == QPIDI) ||
                        (io_inst == DPIEN) || (io_inst == DPIDI) ||
                        (io_inst == OPIEN) || (io_inst == OPIDI);
        switch_legal  = 1'b0;
        switch_target = mode_reg;
        case (mode_reg)
            LANE_SPI: begin
                if (io_inst == QPIEN) begin
                    switch_legal  = 1'b1;
                    switch_target = LANE_QPI;
                end else if (io_inst == DPIEN && DPI_EN) begin
                    switch_legal  = 1'b1;
                    switch_target = LANE_DPI;
                end else if (io_inst == OPIEN && OPI_EN) begin
                    switch_legal  = 1'b1;
                    switch_target = LANE_OPI;
                end
            end
            LANE_DPI: begin
                if (io_inst == DPIDI) begin
                    switch_legal  = 1'b1;
                    switch_target = LANE_SPI;
                end else if (io_inst == QPIEN) begin
                    switch_legal  = 1'b1;
                    switch_target = LANE_QPI;
                end
            end
            LANE_QPI: begin
                if (io_inst == QPIDI) begin
                    switch_legal  = 1'b1;
                    switch_target = LANE_SPI;
                end
            end
            default: begin
                if (io_inst == OPIDI) begin
                    switch_legal  = 1'b1;
                    switch_target = LANE_SPI;
                end
            end
        endcase
    end

    // A command from the sequencer always beats a same-cycle force request.
    assign force_accept   = io_force_valid && (state_reg == IDLE) && !io_next_req;
    assign io_force_ready = force_accept;

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        pend_next  = pend_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (io_next_req) begin
                    if (switch_legal) begin
                        pend_next  = switch_target;
                        state_next = PEND;
                    end else if (is_mode_op) begin
                        err_next = 1'b1;
                    end
                end else if (force_accept) begin
                    if (lane_ok(io_force_mode)) begin
                        mode_next = io_force_mode;
                        if (HAS_RECOV) begin
                            cnt_next   = RECOV_LD;
                            state_next = RECOV;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            PEND: begin
                if (io_next_req && is_mode_op) err_next = 1'b1;
                // Commit only at the transaction boundary so the mode never
                // changes under an active chip select.
                if (io_tran_done) begin
                    mode_next = pend_reg;
                    if (HAS_RECOV) begin
                        cnt_next   = RECOV_LD;
                        state_next = RECOV;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            RECOV: begin
                if (io_next_req && is_mode_op) err_next = 1'b1;
                if (cnt_reg <= 8'd1) begin
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mode_reg  <= LANE_SPI;
            pend_reg  <= LANE_SPI;
            cnt_reg   <= 8'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            pend_reg  <= pend_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Address phase wins when both phase flags are set; an override code the
    // device cannot run falls back to the committed mode.
    always_comb begin
        io_lane_sel = mode_reg;
        if (io_state_addr) begin
            if (io_addr_mode_en && lane_ok(io_addr_lanes)) io_lane_sel = io_addr_lanes;
        end else if (io_state_data) begin
            if (io_data_mode_en && lane_ok(io_data_lanes)) io_lane_sel = io_data_lanes;
        end
    end

    assign io_tran_mode = mode_reg;
    assign io_mode_busy = (state_reg != IDLE);
    assign io_mode_err  = err_reg;

endmodule

// File: tb/tb_qspi_lane_mode_ctrl.sv
module tb_qspi_lane_mode_ctrl;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       io_next_req = 1'b0;
    logic [7:0] io_inst = 8'h00;
    logic       io_tran_done = 1'b0;
    logic       io_state_addr = 1'b0;
    logic       io_state_data = 1'b0;
    logic       io_addr_mode_en = 1'b0;
    logic [1:0] io_addr_lanes = 2'b00;
    logic       io_data_mode_en = 1'b0;
    logic [1:0] io_data_lanes = 2'b00;
    logic       io_force_valid = 1'b0;
    logic [1:0] io_force_mode = 2'b00;
    logic       io_force_ready;
    logic [1:0] io_lane_sel;
    logic [1:0] io_tran_mode;
    logic       io_mode_busy;
    logic       io_mode_err;

    int n_cmp  = 0;
    int n_fail = 0;

    qspi_lane_mode_ctrl dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .io_next_req     (io_next_req),
        .io_inst         (io_inst),
        .io_tran_done    (io_tran_done),
        .io_state_addr   (io_state_addr),
        .io_state_data   (io_state_data),
        .io_addr_mode_en (io_addr_mode_en),
        .io_addr_lanes   (io_addr_lanes),
        .io_data_mode_en (io_data_mode_en),
        .io_data_lanes   (io_data_lanes),
        .io_force_valid  (io_force_valid),
        .io_force_mode   (io_force_mode),
        .io_force_ready  (io_force_ready),
        .io_lane_sel     (io_lane_sel),
        .io_tran_mode    (io_tran_mode),
        .io_mode_busy    (io_mode_busy),
        .io_mode_err     (io_mode_err)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    task automatic check_state(input string tag, input logic [1:0] mode,
                               input logic busy, input logic err);
        check({tag, ".mode"}, 8'(io_tran_mode), 8'(mode));
        check({tag, ".busy"}, 8'(io_mode_busy), 8'(busy));
        check({tag, ".err"},  8'(io_mode_err),  8'(err));
    endtask

    // Issue a legal switch, end the transaction, and ride out recovery.
    task automatic switch_mode(input logic [7:0] inst, input logic [1:0] target);
        io_next_req = 1'b1; io_inst = inst;
        tick();
        io_next_req = 1'b0; io_inst = 8'h00;
        io_tran_done = 1'b1;
        tick();
        io_tran_done = 1'b0;
        check("sw.commit_mode", 8'(io_tran_mode), 8'(target));
        repeat (4) tick();
        check("sw.idle", 8'(io_mode_busy), 8'd0);
    endtask

    task automatic force_to(input logic [1:0] target);
        io_force_valid = 1'b1; io_force_mode = target;
        tick();
        io_force_valid = 1'b0;
        check("force.mode", 8'(io_tran_mode), 8'(target));
        repeat (4) tick();
        check("force.idle", 8'(io_mode_busy), 8'd0);
    endtask

    initial begin
        // ---- reset ----
        repeat (3) tick();
        #1;
        check_state("rst", 2'b00, 1'b0, 1'b0);
        check("rst.lane", 8'(io_lane_sel), 8'd0);
        check("rst.ready", 8'(io_force_ready), 8'd0);
        rst_n = 1'b1;
        tick();
        check_state("idle", 2'b00, 1'b0, 1'b0);

        // ---- SPI -> QPI with tran_done five cycles after the command ----
        io_next_req = 1'b1; io_inst = 8'h35;
        tick();
        io_next_req = 1'b0; io_inst = 8'h00;
        check_state("qpien.pend", 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state("qpien.wait", 2'b00, 1'b1, 1'b0);
        end
        io_tran_done = 1'b1;
        tick();
        io_tran_done = 1'b0;
        check_state("qpien.commit", 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("qpien.recov", 2'b10, 1'b1, 1'b0);
        end
        tick();
        check_state("qpien.done", 2'b10, 1'b0, 1'b0);
        check("qpi.lane", 8'(io_lane_sel), 8'd2);

        // ---- QPIEN while already QPI: error pulse, no change ----
        io_next_req = 1'b1; io_inst = 8'h35;
        tick();
        io_next_req = 1'b0; io_inst = 8'h00;
        check_state("qpien_in_qpi", 2'b10, 1'b0, 1'b1);
        tick();
        check_state("qpien_in_qpi.after", 2'b10, 1'b0, 1'b0);

        // ---- back to SPI, then non-mode opcode and disabled OPIEN ----
        switch_mode(8'hF5, 2'b00);
        io_next_req = 1'b1; io_inst = 8'h03;
        tick();
        io_next_req = 1'b0;
        check_state("read_op", 2'b00, 1'b0, 1'b0);
        io_next_req = 1'b1; io_inst = 8'hE8;
        tick();
        io_next_req = 1'b0;
        check_state("opien_dis", 2'b00, 1'b0, 1'b1);

        // ---- SPI -> DPI and lane overrides ----
        switch_mode(8'h37, 2'b01);
        io_state_addr = 1'b1; io_addr_mode_en = 1'b1; io_addr_lanes = 2'b00; #1;
        check("dpi.addr_ovr", 8'(io_lane_sel), 8'd0);
        io_addr_mode_en = 1'b0; #1;
        check("dpi.addr_noovr", 8'(io_lane_sel), 8'd1);
        io_state_addr = 1'b0; io_state_data = 1'b1; #1;
        check("dpi.data_noovr", 8'(io_lane_sel), 8'd1);
        io_data_mode_en = 1'b1; io_data_lanes = 2'b10; #1;
        check("dpi.data_ovr", 8'(io_lane_sel), 8'd2);
        io_data_lanes = 2'b11; #1;
        check("dpi.data_unsup", 8'(io_lane_sel), 8'd1);
        io_data_lanes = 2'b10; io_state_addr = 1'b1;
        io_addr_mode_en = 1'b1; io_addr_lanes = 2'b00; #1;
        check("dpi.both_phases", 8'(io_lane_sel), 8'd0);
        io_state_addr = 1'b0; io_state_data = 1'b0;
        io_addr_mode_en = 1'b0; io_data_mode_en = 1'b0;

        // ---- DPI: illegal QPIDI, then mode op during PEND ----
        io_next_req = 1'b1; io_inst = 8'hF5;
        tick();
        io_next_req = 1'b0;
        check_state("qpidi_in_dpi", 2'b01, 1'b0, 1'b1);
        io_next_req = 1'b1; io_inst = 8'hFF;
        tick();
        io_inst = 8'h35;
        check_state("dpidi.pend", 2'b01, 1'b1, 1'b0);
        tick();
        io_next_req = 1'b0;
        check_state("op_in_pend", 2'b01, 1'b1, 1'b1);
        io_tran_done = 1'b1;
        tick();
        io_tran_done = 1'b0;
        check_state("dpidi.commit", 2'b00, 1'b1, 1'b0);
        repeat (4) tick();
        check_state("dpidi.done", 2'b00, 1'b0, 1'b0);

        // ---- force handshake: same-cycle next_req wins ----
        io_force_valid = 1'b1; io_force_mode = 2'b10;
        io_next_req = 1'b1; io_inst = 8'h03; #1;
        check("force.blocked_ready", 8'(io_force_ready), 8'd0);
        tick();
        io_next_req = 1'b0; io_inst = 8'h00; #1;
        check_state("force.blocked", 2'b00, 1'b0, 1'b0);
        check("force.ready", 8'(io_force_ready), 8'd1);
        tick();
        io_force_valid = 1'b0;
        check_state("force.accept", 2'b10, 1'b1, 1'b0);
        io_force_valid = 1'b1; io_force_mode = 2'b00; #1;
        check("force.busy_ready", 8'(io_force_ready), 8'd0);
        io_force_valid = 1'b0;
        repeat (4) tick();
        check_state("force.recov_end", 2'b10, 1'b0, 1'b0);

        // ---- unsupported force mode: accepted, error, no change ----
        io_force_valid = 1'b1; io_force_mode = 2'b11; #1;
        check("force_opi.ready", 8'(io_force_ready), 8'd1);
        tick();
        io_force_valid = 1'b0;
        check_state("force_opi", 2'b10, 1'b0, 1'b1);

        // ---- async reset while a switch is pending ----
        force_to(2'b01);
        io_next_req = 1'b1; io_inst = 8'h35;
        tick();
        io_next_req = 1'b0; io_inst = 8'h00;
        check_state("dpi_qpien.pend", 2'b01, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_state("async_rst", 2'b00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        io_tran_done = 1'b1;
        tick();
        io_tran_done = 1'b0;
        check_state("post_rst_done", 2'b00, 1'b0, 1'b0);
        tick();
        check_state("post_rst_idle", 2'b00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
